branch_ctrl: RTL

- Execute-stage controller that sequences branch/jump resolution.
- Qualifies the comparator result (jamp_state_pre) against the decoded instruction class and computes the target.
- Drives a valid/ready redirect handshake to Fetch, then flushes the Fetch/Decode stages for a fixed window.
- Sits between Decode/Execute outputs and the Fetch PC mux.

---
 rtl/branch_ctrl_pkg.sv | 19 +
 rtl/branch_ctrl_if.sv | 13 +
 rtl/branch_ctrl_target_calc.sv | 25 ++
 rtl/branch_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for the branch/jump resolution controller.
package branch_ctrl_pkg;

  localparam int BR_XLEN             = 32;
  localparam int BR_FLUSH_CYCLES_DEF = 2;
  localparam int BR_FLUSH_CNT_W      = 4;

  typedef enum logic [1:0] {
    BR_ST_IDLE     = 2'd0,
    BR_ST_REDIRECT = 2'd1,
    BR_ST_FLUSH    = 2'd2
  } br_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] br_sat_inc(input logic [31:0] cnt);
    return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Redirect handshake between the branch controller (master) and the Fetch PC mux (slave).
interface branch_ctrl_if
  import branch_ctrl_pkg::*;
#(
  parameter int XLEN = BR_XLEN
);
  logic            redirect_valid;
  logic            redirect_ready;
  logic [XLEN-1:0] redirect_pc;

  modport master (output redirect_valid, output redirect_pc, input redirect_ready);
  modport slave  (input redirect_valid, input redirect_pc, output redirect_ready);
endinterface

// File: rtl/branch_ctrl_target_calc.sv
// Combinational branch/jump target calculation; kept standalone so a predictor can reuse it.
module branch_target_calc
  import branch_ctrl_pkg::*;
#(
  parameter int XLEN = BR_XLEN
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic            is_jalr,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  logic [XLEN-1:0] base;
  logic [XLEN-1:0] sum;

  assign base = is_jalr ? rs1 : pc;
  assign sum  = base + imm;

  // JALR drops bit 0 of the computed address; PC-relative targets pass through.
  assign target     = is_jalr ? {sum[XLEN-1:1], 1'b0} : sum;
  assign misaligned = target[1];

endmodule

// File: rtl/branch_ctrl.sv
// Execute-stage branch/jump controller: redirect handshake to Fetch, then a fixed flush window.
// Optional macro BRANCH_PERF_EN adds saturating accepted/redirect counters.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int XLEN         = BR_XLEN,
  parameter int FLUSH_CYCLES = BR_FLUSH_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_in,
  input  logic                valid_de,
  input  logic                is_branch_de,
  input  logic                is_jal_de,
  input  logic                is_jalr_de,
  input  logic                jamp_state_pre,
  input  logic [XLEN-1:0]     pc_de,
  input  logic [XLEN-1:0]     imm_de,
  input  logic [XLEN-1:0]     rs1data_de,
  branch_ctrl_if.master       redir,
  output logic                flush_fd,
  output logic                stall_de,
  output logic                misalign_err,
`ifdef BRANCH_PERF_EN
  output logic [31:0]         perf_branch_cnt,
  output logic [31:0]         perf_taken_cnt,
`endif
  output logic                busy
);

  localparam logic [BR_FLUSH_CNT_W-1:0] FLUSH_LOAD = BR_FLUSH_CNT_W'(FLUSH_CYCLES);

  br_state_e                 state_reg;
  logic [BR_FLUSH_CNT_W-1:0] flush_cnt_reg;
  logic                      redirect_valid_reg;
  logic [XLEN-1:0]           redirect_pc_reg;
  logic                      flush_fd_reg;
  logic                      stall_de_reg;
  logic                      misalign_err_reg;
  logic                      busy_reg;

  logic            accept;
  logic            taken;
  logic            handshake;
  logic [XLEN-1:0] target;
  logic            target_misaligned;

  branch_target_calc #(
    .XLEN (XLEN)
  ) u_target_calc (
    .pc         (pc_de),
    .imm        (imm_de),
    .rs1        (rs1data_de),
    .is_jalr    (is_jalr_de),
    .target     (target),
    .misaligned (target_misaligned)
  );

  assign accept    = (state_reg == BR_ST_IDLE) & valid_de & ~stall_in
                   & (is_branch_de | is_jal_de | is_jalr_de);
  assign taken     = is_jal_de | is_jalr_de | (is_branch_de & jamp_state_pre);
  assign handshake = (state_reg == BR_ST_REDIRECT) & redir.redirect_ready;

  // All outputs are registered alongside the state so they change only at clock edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= BR_ST_IDLE;
      flush_cnt_reg      <= '0;
      redirect_valid_reg <= 1'b0;
      redirect_pc_reg    <= '0;
      flush_fd_reg       <= 1'b0;
      stall_de_reg       <= 1'b0;
      misalign_err_reg   <= 1'b0;
      busy_reg           <= 1'b0;
    end else begin
      misalign_err_reg <= 1'b0;
      case (state_reg)
        BR_ST_IDLE: begin
          if (accept && taken) begin
            if (target_misaligned) begin
              misalign_err_reg <= 1'b1;
            end else begin
              state_reg          <= BR_ST_REDIRECT;
              redirect_pc_reg    <= target;
              redirect_valid_reg <= 1'b1;
              flush_fd_reg       <= 1'b1;
              stall_de_reg       <= 1'b1;
              busy_reg           <= 1'b1;
            end
          end
        end
        BR_ST_REDIRECT: begin
          if (handshake) begin
            state_reg          <= BR_ST_FLUSH;
            flush_cnt_reg      <= FLUSH_LOAD;
            redirect_valid_reg <= 1'b0;
          end
        end
        BR_ST_FLUSH: begin
          if (flush_cnt_reg == BR_FLUSH_CNT_W'(1)) begin
            state_reg     <= BR_ST_IDLE;
            flush_cnt_reg <= '0;
            flush_fd_reg  <= 1'b0;
            stall_de_reg  <= 1'b0;
            busy_reg      <= 1'b0;
          end else begin
            flush_cnt_reg <= flush_cnt_reg - BR_FLUSH_CNT_W'(1);
          end
        end
        default: begin
          state_reg          <= BR_ST_IDLE;
          flush_cnt_reg      <= '0;
          redirect_valid_reg <= 1'b0;
          flush_fd_reg       <= 1'b0;
          stall_de_reg       <= 1'b0;
          busy_reg           <= 1'b0;
        end
      endcase
    end
  end

  assign redir.redirect_valid = redirect_valid_reg;
  assign redir.redirect_pc    = redirect_pc_reg;
  assign flush_fd             = flush_fd_reg;
  assign stall_de             = stall_de_reg;
  assign misalign_err         = misalign_err_reg;
  assign busy                 = busy_reg;

`ifdef BRANCH_PERF_EN
  // Slot 0 counts accepted instructions, slot 1 counts completed redirects.
  logic [1:0]  perf_inc;
  logic [31:0] perf_cnt_reg [2];

  assign perf_inc[0] = accept;
  assign perf_inc[1] = handshake;

  for (genvar gi = 0; gi < 2; gi++) begin : g_perf
    always_ff @(posedge clk) begin
      if (rst) begin
        perf_cnt_reg[gi] <= '0;
      end else if (perf_inc[gi]) begin
        perf_cnt_reg[gi] <= br_sat_inc(perf_cnt_reg[gi]);
      end
    end
  end

  assign perf_branch_cnt = perf_cnt_reg[0];
  assign perf_taken_cnt  = perf_cnt_reg[1];
`endif

endmodule
